// File: rtl/vadd_float_pkg.sv
// Float field widths and helpers shared by the vadd float stages.
package vadd_float_pkg;
  localparam int FLOAT_W = 32;
  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;

  // Quiet or signalling NaN: all-ones exponent with a non-zero mantissa.
  function automatic logic is_nan(input logic [FLOAT_W-1:0] f);
    return (f[FLOAT_W-2 -: EXP_W] == {EXP_W{1'b1}}) && (f[MAN_W-1:0] != '0);
  endfunction
endpackage

// File: rtl/vadd_axis_out_reg.sv
// One-deep AXI4-Stream holding register; loads one cycle after a close, reloads on drain+load.
// Ready to the producer is combinational: empty or draining this cycle.
module vadd_axis_out_reg
  import vadd_float_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int KEEP_W = DATA_W / 8
) (
  input  logic              ap_aclk,
  input  logic              ap_aresetn,
  input  logic              load,
  input  logic [DATA_W-1:0] load_tdata,
  input  logic [KEEP_W-1:0] load_tkeep,
  input  logic              load_tlast,
  output logic              load_rdy,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast
);

  assign load_rdy = ~m_axis_tvalid | m_axis_tready;

  // A load is only issued while load_rdy is high, so a stalled word never changes.
  always_ff @(posedge ap_aclk or negedge ap_aresetn) begin
    if (!ap_aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= load_tdata;
      m_axis_tkeep  <= load_tkeep;
      m_axis_tlast  <= load_tlast;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/vadd_float_result_packer.sv
// Packs 32-bit float results into wide words (lane 0 earliest); closes on full word or tlast, 1-cycle latency.
// Input stalls while the output word is held; VADD_PACK_NAN_EN adds a sticky registered nan_seen flag.
module vadd_float_result_packer
  import vadd_float_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_M_AXIS_TDATA_WIDTH = 512,
  localparam int LP_LANES   = C_M_AXIS_TDATA_WIDTH / 32,
  localparam int LP_LANE_W  = $clog2(LP_LANES)
) (
  input  logic                              ap_aclk,
  input  logic                              ap_aresetn,
  input  logic                              s_axis_c_tvalid,
  output logic                              s_axis_c_tready,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_c_tdata,
  input  logic [3:0]                        s_axis_c_tkeep,
  input  logic                              s_axis_c_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                              m_axis_tlast
`ifdef VADD_PACK_NAN_EN
  ,
  output logic                              nan_seen
`endif
);

  if (C_S_AXIS_TDATA_WIDTH != FLOAT_W) begin : g_bad_s_width
    $error("C_S_AXIS_TDATA_WIDTH must be 32");
  end
  if ((C_M_AXIS_TDATA_WIDTH < 64) || (C_M_AXIS_TDATA_WIDTH % 32 != 0) ||
      ((LP_LANES & (LP_LANES - 1)) != 0)) begin : g_bad_m_width
    $error("C_M_AXIS_TDATA_WIDTH must be a power-of-two multiple of 32, at least 64");
  end

  logic                              rdy;
  logic                              accept;
  logic                              close;
  logic [LP_LANE_W-1:0]              lane;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]   asm_dat;
  logic [LP_LANES-1:0]               asm_mask;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]   word_dat;
  logic [LP_LANES-1:0]               word_mask;
  logic [C_M_AXIS_TDATA_WIDTH/8-1:0] word_keep;
  logic                              unused_tkeep;

  // Every input beat is a whole float, so its byte enables carry no information.
  assign unused_tkeep = &{1'b0, s_axis_c_tkeep};

  assign s_axis_c_tready = rdy;
  assign accept          = s_axis_c_tvalid & rdy;
  assign close           = accept & ((lane == LP_LANE_W'(LP_LANES - 1)) | s_axis_c_tlast);

  // Word as it would look with the current beat merged in.
  always_comb begin
    word_dat  = asm_dat;
    word_mask = asm_mask;
    word_keep = '0;
    word_dat[{lane, 5'd0} +: 32] = s_axis_c_tdata;
    word_mask[lane]              = 1'b1;
    for (int i = 0; i < LP_LANES; i++) begin
      word_keep[4*i +: 4] = {4{word_mask[i]}};
    end
  end

  always_ff @(posedge ap_aclk or negedge ap_aresetn) begin
    if (!ap_aresetn) begin
      asm_dat  <= '0;
      asm_mask <= '0;
      lane     <= '0;
    end else if (accept) begin
      if (close) begin
        asm_dat  <= '0;
        asm_mask <= '0;
        lane     <= '0;
      end else begin
        asm_dat  <= word_dat;
        asm_mask <= word_mask;
        lane     <= lane + 1'b1;
      end
    end
  end

  vadd_axis_out_reg #(
    .DATA_W (C_M_AXIS_TDATA_WIDTH),
    .KEEP_W (C_M_AXIS_TDATA_WIDTH / 8)
  ) u_out_reg (
    .ap_aclk       (ap_aclk),
    .ap_aresetn    (ap_aresetn),
    .load          (close),
    .load_tdata    (word_dat),
    .load_tkeep    (word_keep),
    .load_tlast    (s_axis_c_tlast),
    .load_rdy      (rdy),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast)
  );

`ifdef VADD_PACK_NAN_EN
  always_ff @(posedge ap_aclk or negedge ap_aresetn) begin
    if (!ap_aresetn) begin
      nan_seen <= 1'b0;
    end else if (accept && is_nan(s_axis_c_tdata)) begin
      nan_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vadd_float_result_packer.sv
// Directed bench for vadd_float_result_packer (512-bit output, 16 lanes) with an output scoreboard.
module tb_vadd_float_result_packer;
  localparam int M_W   = 512;
  localparam int LANES = 16;

  typedef struct packed {
    logic [M_W-1:0]   d;
    logic [M_W/8-1:0] k;
    logic             l;
  } word_t;

  logic             ap_aclk = 1'b0;
  logic             ap_aresetn;
  logic             s_axis_c_tvalid;
  logic             s_axis_c_tready;
  logic [31:0]      s_axis_c_tdata;
  logic [3:0]       s_axis_c_tkeep;
  logic             s_axis_c_tlast;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic [M_W-1:0]   m_axis_tdata;
  logic [M_W/8-1:0] m_axis_tkeep;
  logic             m_axis_tlast;
`ifdef VADD_PACK_NAN_EN
  logic             nan_seen;
`endif

  vadd_float_result_packer #(
    .C_S_AXIS_TDATA_WIDTH (32),
    .C_M_AXIS_TDATA_WIDTH (M_W)
  ) dut (
    .ap_aclk         (ap_aclk),
    .ap_aresetn      (ap_aresetn),
    .s_axis_c_tvalid (s_axis_c_tvalid),
    .s_axis_c_tready (s_axis_c_tready),
    .s_axis_c_tdata  (s_axis_c_tdata),
    .s_axis_c_tkeep  (s_axis_c_tkeep),
    .s_axis_c_tlast  (s_axis_c_tlast),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tlast    (m_axis_tlast)
`ifdef VADD_PACK_NAN_EN
    ,
    .nan_seen        (nan_seen)
`endif
  );

  always #5 ap_aclk = ~ap_aclk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge ap_aclk) cyc <= cyc + 1;

  word_t          q[$];
  logic [M_W-1:0]   exp_dat;
  logic [M_W/8-1:0] exp_keep;
  int             exp_lane;

  task automatic check(input string tag, input logic [M_W-1:0] obs, input logic [M_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_dat  = '0;
    exp_keep = '0;
    exp_lane = 0;
  endtask

  // Reference packing: lane placement, close on last lane or tlast.
  task automatic model_accept(input logic [31:0] d, input logic last);
    word_t w;
    exp_dat[32*exp_lane +: 32] = d;
    exp_keep[4*exp_lane +: 4]  = 4'hF;
    if (exp_lane == LANES - 1 || last) begin
      w.d = exp_dat;
      w.k = exp_keep;
      w.l = last;
      q.push_back(w);
      model_clear();
    end else begin
      exp_lane++;
    end
  endtask

  task automatic sync();
    @(posedge ap_aclk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input logic [31:0] d, input logic last);
    int n;
    s_axis_c_tvalid = 1'b1;
    s_axis_c_tdata  = d;
    s_axis_c_tlast  = last;
    n = 0;
    @(negedge ap_aclk);
    while (!s_axis_c_tready && n < 100) begin
      @(negedge ap_aclk);
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $error("FAIL send_timeout: observed no s_tready expected s_tready within 100 cycles");
    end
    model_accept(d, last);
    sync();
    s_axis_c_tvalid = 1'b0;
    s_axis_c_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    ap_aresetn      = 1'b0;
    s_axis_c_tvalid = 1'b0;
    s_axis_c_tlast  = 1'b0;
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata",  m_axis_tdata,  0);
    check("rst_tkeep",  m_axis_tkeep,  0);
    check("rst_tlast",  m_axis_tlast,  0);
`ifdef VADD_PACK_NAN_EN
    check("rst_nan",    nan_seen,      0);
`endif
    model_clear();
    q.delete();
    sync();
    ap_aresetn = 1'b1;
    @(negedge ap_aclk);
    check("rst_s_tready", s_axis_c_tready, 1);
    sync();
  endtask

  // Scoreboard: every output handshake is compared against the oldest expected word.
  word_t mon_w;
  always @(negedge ap_aclk) begin
    if (ap_aresetn && m_axis_tvalid && m_axis_tready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL sb_unexpected: observed word %0h expected no word", m_axis_tdata);
      end else begin
        mon_w = q.pop_front();
        check("sb_tdata", m_axis_tdata, mon_w.d);
        check("sb_tkeep", m_axis_tkeep, mon_w.k);
        check("sb_tlast", m_axis_tlast, mon_w.l);
      end
    end
  end

  initial begin
    word_t hold;
    int    c0;
    int    n;
    ap_aresetn      = 1'b0;
    s_axis_c_tvalid = 1'b0;
    s_axis_c_tdata  = '0;
    s_axis_c_tkeep  = 4'hF;
    s_axis_c_tlast  = 1'b0;
    m_axis_tready   = 1'b0;
    model_clear();
    #3;
    check("init_tvalid", m_axis_tvalid, 0);
    check("init_tdata",  m_axis_tdata,  0);
    check("init_tkeep",  m_axis_tkeep,  0);
    check("init_tlast",  m_axis_tlast,  0);
    sync();
    ap_aresetn = 1'b1;
    @(negedge ap_aclk);
    check("init_s_tready", s_axis_c_tready, 1);
    sync();

    // Full word closed by tlast on lane 15.
    m_axis_tready = 1'b1;
    for (int i = 0; i < 15; i++) send(32'h3F80_0000 + i, 1'b0);
    @(negedge ap_aclk);
    check("full_not_early", m_axis_tvalid, 0);
    sync();
    send(32'h3F80_000F, 1'b1);
    @(negedge ap_aclk);
    check("full_latency", m_axis_tvalid, 1);
    check("full_tkeep", m_axis_tkeep, {64{1'b1}});
    check("full_tlast", m_axis_tlast, 1);
    sync();

    // Partial flush held under backpressure, then drain and close on the same edge.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) send(32'h4000_0000 + i, i == 4);
    @(negedge ap_aclk);
    check("partial_tkeep", m_axis_tkeep, 64'h0000_0000_000F_FFFF);
    s_axis_c_tvalid = 1'b1;
    s_axis_c_tdata  = 32'h4100_0000;
    s_axis_c_tlast  = 1'b1;
    @(negedge ap_aclk);
    check("partial_stall_rdy", s_axis_c_tready, 0);
    sync();
    m_axis_tready = 1'b1;
    send(32'h4100_0000, 1'b1);
    @(negedge ap_aclk);
    check("reload_tvalid", m_axis_tvalid, 1);
    check("reload_tkeep", m_axis_tkeep, 64'hF);
    sync();

    // 40-beat vector: 16 + 16 + 8 lanes, no input bubbles.
    c0 = cyc;
    for (int i = 0; i < 40; i++) send(32'h4200_0000 + i, i == 39);
    check("multi_no_bubble", cyc - c0, 40);
    repeat (2) sync();

    // Output stalled for 10 cycles after the first word.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) send(32'h4300_0000 + i, 1'b0);
    check("bp_queue_depth", q.size(), 1);
    hold = (q.size() > 0) ? q[0] : '0;
    s_axis_c_tvalid = 1'b1;
    s_axis_c_tdata  = 32'h4300_0010;
    repeat (10) begin
      @(negedge ap_aclk);
      check("bp_s_tready", s_axis_c_tready, 0);
      check("bp_tvalid", m_axis_tvalid, 1);
      check("bp_tdata_stable", m_axis_tdata, hold.d);
    end
    sync();
    m_axis_tready = 1'b1;
    send(32'h4300_0010, 1'b0);
    send(32'h4300_0011, 1'b0);
    send(32'h4300_0012, 1'b1);
    repeat (2) sync();

    // Reset after 7 beats discards the partial word; next vector starts at lane 0.
    for (int i = 0; i < 7; i++) send(32'h4400_0000 + i, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) send(32'h4500_0000 + i, i == 2);
    repeat (2) sync();

    // Reset while a word is held unsent.
    m_axis_tready = 1'b0;
    send(32'h4600_0000, 1'b1);
    check("held_before_rst", m_axis_tvalid, 1);
    do_reset();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 2; i++) send(32'h4700_0000 + i, i == 1);

`ifdef VADD_PACK_NAN_EN
    send(32'h7F80_0000, 1'b1);
    @(negedge ap_aclk);
    check("nan_inf_clear", nan_seen, 0);
    sync();
    send(32'h7FC0_0000, 1'b0);
    @(negedge ap_aclk);
    check("nan_set", nan_seen, 1);
    sync();
    send(32'h3F80_0000, 1'b1);
    repeat (3) sync();
    check("nan_sticky", nan_seen, 1);
`endif

    m_axis_tready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge ap_aclk);
      n++;
    end
    check("drain_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vadd_float_result_packer.md
# vadd_float_result_packer

Downstream neighbour of the float adder in the vadd datapath. Consumes the adder's 32-bit AXI4-Stream result (one float per beat) and packs consecutive results into wide words for the memory-write side. A word closes when all lanes are filled or the input `tlast` arrives. A partial final word is flushed with `tkeep` cleared on its unfilled lanes.

## Interface
Parameters:
- `C_S_AXIS_TDATA_WIDTH`, default 32: input element width. Fixed at 32; elaboration error otherwise.
- `C_M_AXIS_TDATA_WIDTH`, default 512: output word width. Must be a power-of-two multiple of 32, at least 64.
- Derived `LP_LANES` = `C_M_AXIS_TDATA_WIDTH/32`; `LP_LANE_W` = `$clog2(LP_LANES)`.

Ports:
- `ap_aclk`, in, 1: clock; all logic on the rising edge.
- `ap_aresetn`, in, 1: reset, asynchronous, active-low.
- `s_axis_c_tvalid`, in, 1: input beat valid.
- `s_axis_c_tready`, out, 1: input ready.
- `s_axis_c_tdata`, in, 32: float result.
- `s_axis_c_tkeep`, in, 4: ignored; always treated as 4'hF.
- `s_axis_c_tlast`, in, 1: last element of the vector.
- `m_axis_tvalid`, out, 1: packed word valid.
- `m_axis_tready`, in, 1: downstream ready.
- `m_axis_tdata`, out, `C_M_AXIS_TDATA_WIDTH`: packed word.
- `m_axis_tkeep`, out, `C_M_AXIS_TDATA_WIDTH/8`: byte enables, 4 bits per filled lane.
- `m_axis_tlast`, out, 1: word closed by input `tlast`.
- `nan_seen`, out, 1: present only with `VADD_PACK_NAN_EN` (see Configuration).

## Operation
- **Assembly.** An assembly register holds the word being built, with lane pointer `lane` (0..`LP_LANES`-1) and a per-lane fill mask.
- **Lane placement.** An accepted beat (`s_tvalid & s_tready`) writes `tdata` to bits [32·`lane`+31 : 32·`lane`] and sets that lane's mask bit. Lane 0 holds the earliest element (little-endian lane order).
- **Close condition.** The word closes on an accepted beat with `lane == LP_LANES-1` or with `s_tlast = 1`.
- **On close.**
  - Data, mask-expanded `tkeep` and `tlast` move into the output holding register; `m_tvalid` is set.
  - Assembly register data and mask are cleared and `lane` returns to 0.
  - Input `tlast` on lane `LP_LANES-1` gives a full word with `tlast = 1`.
- **Non-closing beat.** `lane` increments.
- **Unfilled lanes.** Carry `tdata = 0` and `tkeep = 0`.
- **Ready.** `s_axis_c_tready = ~m_axis_tvalid | m_axis_tready`. This is combinational, and stalls every input beat while the output register is occupied and stalled.
- **Output handshake.**
  - `m_tvalid` clears on `m_tvalid & m_tready` unless a new word closes in the same cycle, in which case the register reloads.
  - `m_tdata`, `m_tkeep` and `m_tlast` stay stable while `m_tvalid & ~m_tready`.
- **Reset.**
  - All outputs are 0: `m_tvalid`, `m_tdata`, `m_tkeep`, `m_tlast`, `nan_seen`.
  - `s_tready` reads 1 while `ap_aresetn` is high with an empty output register.
  - A reset asserted mid-vector discards the partial word and any unsent output word.

## Timing
- **Latency.** A closed word is visible on `m_tvalid` in the cycle after the closing beat is accepted.
- **Throughput.** With `m_tready` held at 1: one element per cycle and one output word per `LP_LANES` cycles, with no bubbles.
- **Back-to-back vectors.** A `tlast` beat followed immediately by the next vector's first beat is accepted with no gap. The new element goes into lane 0.
- **Simultaneous events.** Output drained and new word closed in the same edge: the output register reloads and `m_tvalid` stays 1.

## Configuration
- **`VADD_PACK_NAN_EN` defined:**
  - Adds the `nan_seen` port.
  - `nan_seen` is a sticky flag set on any accepted beat with exponent 8'hFF and a non-zero mantissa.
  - It is cleared only by reset, and is registered (visible one cycle after acceptance).
- **Not defined:** the port and its logic are absent, and the datapath is otherwise identical.

## Structure
- **Shared package `vadd_float_pkg`:**
  - `FLOAT_W = 32`.
  - Float field widths: `EXP_W = 8`, `MAN_W = 23`.
  - A float NaN-test function.
  - Used by this block and by future float stages.
- **Sub-module.** `vadd_axis_out_reg` is the output holding register with the valid/ready logic. It is reusable by other vadd stream stages.

## Test plan
The first five scenarios use `LP_LANES = 16` (the default 512-bit output).
- **Full word.** 16 beats 0x3F800000..0x3F80000F with `tlast` on the 16th, `m_tready = 1` → one word: lane i = 0x3F800000+i, `tkeep` all ones, `tlast = 1`, `m_tvalid` one cycle after the 16th accept.
- **Partial flush.** 5 beats with `tlast` on the 5th → `tkeep[19:0]` all ones and `tkeep[63:20]` zero, lanes 5..15 = 0, `tlast = 1`.
- **Multi-word vector.** 40-beat vector → words with 16, 16 and 8 valid lanes. `tlast` only on the third; no input bubbles with `m_tready = 1`.
- **Backpressure.** `m_tready = 0` for 10 cycles after the first word → `s_tready = 0` throughout, output stable, no beats lost; data resumes correct.
- **Reset mid-vector.** `ap_aresetn` low after 7 beats → outputs 0 immediately; the next vector starts packing at lane 0.
- **NaN flag (`VADD_PACK_NAN_EN`).** Beat 0x7FC00000 → `nan_seen = 1` next cycle and it stays high. Beat 0x7F800000 (infinity) alone → `nan_seen` stays 0.
